// File: rtl/noc_vc_input_unit.sv
// Router input unit: one FIFO per virtual channel, credit return on every
// dequeue, and XY route computation for the head flit of each VC.
`timescale 1ns/1ps
module noc_vc_input_unit #(
    parameter int FLIT_W   = 64,
    parameter int VC_NUM   = 2,
    parameter int VC_DEPTH = 4,
    parameter int X_W      = 4,
    parameter int Y_W      = 4,
    parameter int CUR_X    = 0,
    parameter int CUR_Y    = 0,
    parameter int DEST_LSB = 0,
    localparam int VC_W    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [VC_W-1:0]          in_vc,
    input  logic [FLIT_W-1:0]        in_flit,
    output logic [VC_NUM-1:0]        out_valid,
    output logic [VC_NUM*FLIT_W-1:0] out_flit,
    output logic [VC_NUM*5-1:0]      out_route,
    input  logic [VC_NUM-1:0]        out_ready,
    output logic [VC_NUM-1:0]        credit_out,
    output logic                     overflow_err,
    output logic                     proto_err
);

    localparam int CNT_W = $clog2(VC_DEPTH + 1);
    localparam int PTR_W = $clog2(VC_DEPTH);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(VC_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(VC_DEPTH - 1);
    localparam logic [X_W-1:0]   CX       = X_W'(CUR_X);
    localparam logic [Y_W-1:0]   CY       = Y_W'(CUR_Y);

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    localparam logic [4:0] R_EAST  = 5'b00001;
    localparam logic [4:0] R_WEST  = 5'b00010;
    localparam logic [4:0] R_SOUTH = 5'b00100;
    localparam logic [4:0] R_NORTH = 5'b01000;
    localparam logic [4:0] R_LOCAL = 5'b10000;
    localparam logic [4:0] R_NA    = 5'b00000;

    typedef enum logic {VC_IDLE, VC_ACTIVE} vc_state_e;

    // Explicit wrap keeps non-power-of-two depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Dimension-order routing: resolve X first, then Y, else deliver locally.
    function automatic logic [4:0] xy_route(input logic [FLIT_W-1:0] flit);
        logic [X_W-1:0] dx;
        logic [Y_W-1:0] dy;
        dx = flit[DEST_LSB +: X_W];
        dy = flit[DEST_LSB + X_W +: Y_W];
        if (dx > CX)      return R_EAST;
        else if (dx < CX) return R_WEST;
        else if (dy > CY) return R_NORTH;
        else if (dy < CY) return R_SOUTH;
        else              return R_LOCAL;
    endfunction

    logic [FLIT_W-1:0] mem_q    [VC_NUM][VC_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [VC_NUM];
    logic [PTR_W-1:0]  wr_ptr_d [VC_NUM];
    logic [PTR_W-1:0]  rd_ptr_q [VC_NUM];
    logic [PTR_W-1:0]  rd_ptr_d [VC_NUM];
    logic [CNT_W-1:0]  cnt_q    [VC_NUM];
    logic [CNT_W-1:0]  cnt_d    [VC_NUM];
    vc_state_e         state_q  [VC_NUM];
    logic [4:0]        route_q  [VC_NUM];
    logic [FLIT_W-1:0] head     [VC_NUM];
    logic [1:0]        head_type[VC_NUM];

    logic [VC_NUM-1:0] pop;
    logic [VC_NUM-1:0] wr_en;
    logic [VC_NUM-1:0] proto_hit;
    logic              drop;
    logic [VC_NUM-1:0] credit_q;
    logic              ovf_q;
    logic              proto_q;

    // Dequeue/enqueue decisions and next pointer/count values per VC.
    always_comb begin
        // NOTE: every always_comb output is assigned a default first, so no path can leave one unassigned and infer a latch.
        pop   = '0;
        wr_en = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            pop[i]   = (cnt_q[i] != '0) && out_ready[i];
            // A pop in the same cycle frees the slot a full FIFO needs.
            wr_en[i] = in_valid && (in_vc == VC_W'(i)) && ((cnt_q[i] != CNT_FULL) || pop[i]);
            wr_ptr_d[i] = wr_en[i] ? ptr_inc(wr_ptr_q[i]) : wr_ptr_q[i];
            rd_ptr_d[i] = pop[i]   ? ptr_inc(rd_ptr_q[i]) : rd_ptr_q[i];
            cnt_d[i]    = cnt_q[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
        end
        // Covers both a full VC and an out-of-range VC index.
        drop = in_valid && (wr_en == '0);
    end

    // Head-flit presentation, route selection and protocol checking.
    always_comb begin
        out_valid = '0;
        out_flit  = '0;
        out_route = '0;
        proto_hit = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            head[i]      = mem_q[i][rd_ptr_q[i]];
            head_type[i] = head[i][FLIT_W-1 -: 2];
            out_valid[i] = (cnt_q[i] != '0);
            out_flit[i*FLIT_W +: FLIT_W] = head[i];
            if (out_valid[i]) begin
                if (state_q[i] == VC_ACTIVE) begin
                    out_route[i*5 +: 5] = route_q[i];
                    proto_hit[i] = (head_type[i] == T_HEAD) || (head_type[i] == T_SINGLE);
                end else if ((head_type[i] == T_HEAD) || (head_type[i] == T_SINGLE)) begin
                    out_route[i*5 +: 5] = xy_route(head[i]);
                end else begin
                    out_route[i*5 +: 5] = R_NA;
                    proto_hit[i] = 1'b1;
                end
            end
        end
    end

    // Flit storage write port.
    // NOTE: the flit array has no reset; nothing reads an entry before it is written, since out_valid is gated by the count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < VC_NUM; i++) begin
            if (wr_en[i]) mem_q[i][wr_ptr_q[i]] <= in_flit;
        end
    end

    // FIFO pointers, counts, credit pulses and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            for (int i = 0; i < VC_NUM; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            credit_q <= '0;
            ovf_q    <= 1'b0;
            proto_q  <= 1'b0;
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            credit_q <= pop;
            ovf_q    <= ovf_q | drop;
            proto_q  <= proto_q | (proto_hit != '0);
        end
    end

    // Per-VC packet state: a popped head opens a packet, a popped tail closes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < VC_NUM; i++) begin
                state_q[i] <= VC_IDLE;
                route_q[i] <= R_NA;
            end
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                if (pop[i]) begin
                    case (state_q[i])
                        VC_IDLE: begin
                            if (head_type[i] == T_HEAD) begin
                                route_q[i] <= xy_route(head[i]);
                                state_q[i] <= VC_ACTIVE;
                            end
                        end
                        VC_ACTIVE: begin
                            if (head_type[i] == T_TAIL) state_q[i] <= VC_IDLE;
                        end
                        default: state_q[i] <= VC_IDLE;
                    endcase
                end
            end
        end
    end

    assign credit_out   = credit_q;
    assign overflow_err = ovf_q;
    assign proto_err    = proto_q;

endmodule

// File: tb/tb_noc_vc_input_unit.sv
// Scoreboard bench for noc_vc_input_unit: a packet-level model predicts each
// flit's route and protocol status at enqueue time; a negedge monitor checks
// the DUT's head flits, routes, credits and error flags against it.
`timescale 1ns/1ps
module tb_noc_vc_input_unit;

    localparam int FLIT_W   = 64;
    localparam int VC_NUM   = 2;
    localparam int VC_DEPTH = 4;
    localparam int CUR_X    = 1;
    localparam int CUR_Y    = 1;

    localparam logic [1:0] TY_BODY   = 2'b00;
    localparam logic [1:0] TY_TAIL   = 2'b01;
    localparam logic [1:0] TY_HEAD   = 2'b10;
    localparam logic [1:0] TY_SINGLE = 2'b11;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic [0:0]               in_vc;
    logic [FLIT_W-1:0]        in_flit;
    logic [VC_NUM-1:0]        out_valid;
    logic [VC_NUM*FLIT_W-1:0] out_flit;
    logic [VC_NUM*5-1:0]      out_route;
    logic [VC_NUM-1:0]        out_ready;
    logic [VC_NUM-1:0]        credit_out;
    logic                     overflow_err;
    logic                     proto_err;

    noc_vc_input_unit #(
        .FLIT_W(FLIT_W), .VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH), .X_W(4), .Y_W(4),
        .CUR_X(CUR_X), .CUR_Y(CUR_Y), .DEST_LSB(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
        .out_valid(out_valid), .out_flit(out_flit), .out_route(out_route),
        .out_ready(out_ready), .credit_out(credit_out),
        .overflow_err(overflow_err), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [FLIT_W-1:0] flit;
        logic [4:0]        route;
        logic              proto;
    } exp_t;

    exp_t              sb_q [VC_NUM][$];
    bit                in_pkt [VC_NUM];
    logic [4:0]        pkt_route [VC_NUM];
    logic [VC_NUM-1:0] exp_credit;
    logic              exp_proto;
    logic              exp_ovf;
    int                total = 0;
    int                bad   = 0;

    task automatic check(input string name, input int vc, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s vc%0d actual=%h required=%h @%0t", name, vc, act, req, $time);
        end
    endtask

    function automatic logic [4:0] ref_route(input int dx, input int dy);
        if (dx > CUR_X)      return 5'b00001;
        else if (dx < CUR_X) return 5'b00010;
        else if (dy > CUR_Y) return 5'b01000;
        else if (dy < CUR_Y) return 5'b00100;
        else                 return 5'b10000;
    endfunction

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int dx, input int dy);
        logic [FLIT_W-1:0] f;
        f = {$urandom, $urandom};
        f[63:62] = t;
        f[3:0]   = 4'(dx);
        f[7:4]   = 4'(dy);
        return f;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < VC_NUM; i++) begin
            sb_q[i].delete();
            in_pkt[i]    = 1'b0;
            pkt_route[i] = 5'b0;
        end
        exp_credit = '0;
        exp_proto  = 1'b0;
        exp_ovf    = 1'b0;
    endfunction

    // Model: an accepted flit's route follows from the packet it belongs to,
    // since every flit reaches the FIFO head in arrival order.
    always @(posedge clk) begin
        if (rst_n && in_valid) begin
            int   vc;
            exp_t e;
            vc = int'(in_vc);
            // Monitor already removed this cycle's pop, so the free slot shows here.
            if (sb_q[vc].size() < VC_DEPTH) begin
                logic [1:0] t;
                t = in_flit[63:62];
                e.flit = in_flit;
                if (!in_pkt[vc]) begin
                    if (t == TY_HEAD || t == TY_SINGLE) begin
                        e.route = ref_route(int'(in_flit[3:0]), int'(in_flit[7:4]));
                        e.proto = 1'b0;
                        if (t == TY_HEAD) begin
                            in_pkt[vc]    = 1'b1;
                            pkt_route[vc] = e.route;
                        end
                    end else begin
                        e.route = 5'b0;
                        e.proto = 1'b1;
                    end
                end else begin
                    e.route = pkt_route[vc];
                    e.proto = (t == TY_HEAD || t == TY_SINGLE);
                    if (t == TY_TAIL) in_pkt[vc] = 1'b0;
                end
                sb_q[vc].push_back(e);
            end else begin
                exp_ovf = 1'b1;
            end
        end
    end

    // Monitor: compare every VC's presented head against the scoreboard.
    always @(negedge clk) begin
        logic flag;
        flag = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            bit has;
            has = (sb_q[i].size() != 0);
            check("out_valid", i, 64'(out_valid[i]), 64'(has));
            if (has) begin
                check("out_flit", i, out_flit[i*FLIT_W +: FLIT_W], sb_q[i][0].flit);
                check("out_route", i, 64'(out_route[i*5 +: 5]), 64'(sb_q[i][0].route));
                flag = flag | sb_q[i][0].proto;
            end else begin
                check("idle_route", i, 64'(out_route[i*5 +: 5]), 64'd0);
            end
            check("credit_out", i, 64'(credit_out[i]), 64'(exp_credit[i]));
            exp_credit[i] = has && out_ready[i];
            if (has && out_ready[i]) void'(sb_q[i].pop_front());
        end
        check("proto_err", 0, 64'(proto_err), 64'(exp_proto));
        check("overflow_err", 0, 64'(overflow_err), 64'(exp_ovf));
        exp_proto = exp_proto | flag;
    end

    task automatic drive(input logic v, input int vc, input logic [FLIT_W-1:0] f, input logic [1:0] rdy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_vc     = 1'(vc);
        in_flit   = f;
        out_ready = rdy;
    endtask

    task automatic idle(input int n, input logic [1:0] rdy);
        for (int k = 0; k < n; k++) drive(1'b0, 0, '0, rdy);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        for (int k = 0; k < n; k++) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_clear();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_vc     = 1'b0;
        in_flit   = mk(TY_SINGLE, 3, 3);
        out_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First write after reset: valid appears one cycle later.
        drive(1'b1, 0, mk(TY_SINGLE, 2, 2), 2'b00);
        idle(2, 2'b11);

        // Three-flit packet towards (3,1): EAST on every flit, credits back to back.
        drive(1'b1, 0, mk(TY_HEAD, 3, 1), 2'b11);
        drive(1'b1, 0, mk(TY_BODY, 0, 0), 2'b11);
        drive(1'b1, 0, mk(TY_TAIL, 7, 7), 2'b11);
        idle(3, 2'b11);

        // Single flits on VC1: SOUTH, LOCAL, WEST.
        drive(1'b1, 1, mk(TY_SINGLE, 1, 0), 2'b11);
        drive(1'b1, 1, mk(TY_SINGLE, 1, 1), 2'b11);
        drive(1'b1, 1, mk(TY_SINGLE, 0, 5), 2'b11);
        idle(3, 2'b11);

        // Fill VC0, drop the fifth flit, then write into a full FIFO while popping.
        drive(1'b1, 0, mk(TY_HEAD, 2, 2), 2'b00);
        for (int k = 0; k < 4; k++) drive(1'b1, 0, mk(TY_BODY, 5, 5), 2'b00);
        drive(1'b1, 0, mk(TY_TAIL, 0, 0), 2'b01);
        idle(2, 2'b00);
        idle(6, 2'b11);

        // Interleaved packets on both VCs, popped together.
        drive(1'b1, 0, mk(TY_HEAD, 2, 1), 2'b00);
        drive(1'b1, 1, mk(TY_HEAD, 1, 3), 2'b00);
        drive(1'b1, 0, mk(TY_BODY, 0, 0), 2'b00);
        drive(1'b1, 1, mk(TY_TAIL, 0, 0), 2'b00);
        drive(1'b1, 0, mk(TY_TAIL, 0, 0), 2'b00);
        idle(5, 2'b11);

        // Orphan body at an idle VC, then a head that must route normally.
        drive(1'b1, 1, mk(TY_BODY, 3, 3), 2'b00);
        idle(2, 2'b00);
        idle(1, 2'b10);
        drive(1'b1, 1, mk(TY_HEAD, 1, 0), 2'b10);
        drive(1'b1, 1, mk(TY_TAIL, 3, 3), 2'b10);
        idle(3, 2'b11);

        // Reset in the middle of a packet: contents and packet state are discarded.
        drive(1'b1, 0, mk(TY_HEAD, 3, 1), 2'b00);
        drive(1'b1, 0, mk(TY_BODY, 0, 0), 2'b00);
        do_reset(2);
        drive(1'b1, 0, mk(TY_SINGLE, 1, 0), 2'b00);
        idle(2, 2'b11);

        // Random traffic with mostly well-formed but occasionally illegal type sequences.
        for (int k = 0; k < 600; k++) begin
            drive(1'b1 & ($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
                  mk(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                  2'($urandom_range(0, 3)));
        end

        // Drain with a bounded wait.
        for (int k = 0; k < 40; k++) begin
            drive(1'b0, 0, '0, 2'b11);
            if (sb_q[0].size() == 0 && sb_q[1].size() == 0) break;
        end
        check("drain_vc0", 0, 64'(sb_q[0].size()), 64'd0);
        check("drain_vc1", 1, 64'(sb_q[1].size()), 64'd0);
        idle(2, 2'b11);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
